// File: rtl/axis_pe_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : axis_pe_pipe
//  Purpose  : AXI-stream shell around an external fixed-latency kernel.
//             Accepted beats go to the kernel. Their tdest follows through a
//             latency-matched tag pipeline. Results land in an output FIFO.
//             Admission is gated by credits, so a result is never dropped.
//  Revision : 1.0  initial release
// ============================================================================
module axis_pe_pipe #(
   parameter int DATA_W     = 128,
   parameter int DEST_W     = 1,
   parameter int LATENCY    = 20,
   parameter int FIFO_DEPTH = 32,
   parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              s_tvalid,
   output logic              s_tready,
   input  logic [DATA_W-1:0] s_tdata,
   input  logic [DEST_W-1:0] s_tdest,
   output logic              k_in_valid,
   output logic [DATA_W-1:0] k_in_data,
   input  logic [DATA_W-1:0] k_out_data,
   output logic              m_tvalid,
   input  logic              m_tready,
   output logic [DATA_W-1:0] m_tdata,
   output logic [DEST_W-1:0] m_tdest,
   output logic [CNT_W-1:0]  credits_used
);

   localparam int               PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [CNT_W-1:0] C_DEPTH    = CNT_W'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);
   localparam logic [PTR_W-1:0] C_LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
   localparam logic [PTR_W-1:0] C_PTR_ONE  = PTR_W'(1);

   logic [LATENCY-1:0] r_tag_valid;
   logic [DEST_W-1:0]  r_tag_dest [LATENCY];
   logic [DATA_W-1:0]  r_mem_data [FIFO_DEPTH];
   logic [DEST_W-1:0]  r_mem_dest [FIFO_DEPTH];
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [CNT_W-1:0]   r_fifo_cnt;
   logic [CNT_W-1:0]   r_credits;

   logic w_accept;
   logic w_wr;
   logic w_pop;
   logic w_empty;

   // Admission looks only at registered credits, never at s_tvalid.
   assign s_tready     = !reset && (r_credits < C_DEPTH);
   assign w_accept     = s_tvalid && s_tready;
   assign k_in_valid   = w_accept;
   assign k_in_data    = s_tdata;

   // The last tag stage lines up with the kernel result of the same beat.
   assign w_wr         = r_tag_valid[LATENCY-1];
   assign w_empty      = (r_fifo_cnt == '0);
   assign m_tvalid     = !w_empty;
   assign w_pop        = m_tvalid && m_tready;

   // Head outputs read as zero when empty, so they are clean out of reset.
   assign m_tdata      = w_empty ? '0 : r_mem_data[r_rd_ptr];
   assign m_tdest      = w_empty ? '0 : r_mem_dest[r_rd_ptr];
   assign credits_used = r_credits;

   // Tag pipeline: shift {valid, dest} alongside the kernel's own pipeline.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_tag_valid <= '0;
         for (int i = 0; i < LATENCY; i++) r_tag_dest[i] <= '0;
      end else begin
         r_tag_valid[0] <= w_accept;
         r_tag_dest[0]  <= s_tdest;
         for (int i = 1; i < LATENCY; i++) begin
            r_tag_valid[i] <= r_tag_valid[i-1];
            r_tag_dest[i]  <= r_tag_dest[i-1];
         end
      end
   end

   // FIFO storage: capture the kernel result with the tag's dest.
   always_ff @(posedge clk) begin
      if (w_wr) begin
         r_mem_data[r_wr_ptr] <= k_out_data;
         r_mem_dest[r_wr_ptr] <= r_tag_dest[LATENCY-1];
      end
   end

   // FIFO pointers wrap at FIFO_DEPTH, so any depth works. Occupancy tracks write/pop.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_fifo_cnt <= '0;
      end else begin
         if (w_wr)  r_wr_ptr <= (r_wr_ptr == C_LAST_PTR) ? '0 : r_wr_ptr + C_PTR_ONE;
         if (w_pop) r_rd_ptr <= (r_rd_ptr == C_LAST_PTR) ? '0 : r_rd_ptr + C_PTR_ONE;
         case ({w_wr, w_pop})
            2'b10:   r_fifo_cnt <= r_fifo_cnt + C_CNT_ONE;
            2'b01:   r_fifo_cnt <= r_fifo_cnt - C_CNT_ONE;
            default: r_fifo_cnt <= r_fifo_cnt;
         endcase
      end
   end

   // Credits count beats in flight plus beats buffered: +1 on accept, -1 on pop.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_credits <= '0;
      end else begin
         case ({w_accept, w_pop})
            2'b10:   r_credits <= r_credits + C_CNT_ONE;
            2'b01:   r_credits <= r_credits - C_CNT_ONE;
            default: r_credits <= r_credits;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_axis_pe_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axis_pe_pipe
//  Purpose  : Self-checking bench for axis_pe_pipe. The main instance is
//             20-cycle / 32-deep. Two small instances cover the 1/3 and 5/2
//             parameter corners.
//  Revision : 1.0  initial release
// ============================================================================
module tb_axis_pe_pipe;

   typedef struct packed {
      logic [127:0] data;
      logic         dest;
   } beat_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;

   // clock and edge counter (cyc = number of rising edges seen so far)
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- main instance: LATENCY=20, FIFO_DEPTH=32 ----------------
   logic         s_tvalid, s_tready, s_tdest, k_in_valid, m_tvalid, m_tready, m_tdest;
   logic [127:0] s_tdata, k_in_data, k_out_data, m_tdata;
   logic [5:0]   credits_used;
   logic [127:0] kp [20];
   beat_t        exp_q [$];

   axis_pe_pipe #(.DATA_W(128), .DEST_W(1), .LATENCY(20), .FIFO_DEPTH(32)) dut (
      .clk(clk), .reset(reset),
      .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tdest(s_tdest),
      .k_in_valid(k_in_valid), .k_in_data(k_in_data), .k_out_data(k_out_data),
      .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tdest(m_tdest),
      .credits_used(credits_used)
   );

   // kernel model: result = input + 1, LATENCY edges later
   always @(posedge clk) begin
      kp[0] <= k_in_data + 128'd1;
      for (int i = 1; i < 20; i++) kp[i] <= kp[i-1];
   end
   assign k_out_data = kp[19];

   // ---------------- sweep instance A: LATENCY=1, FIFO_DEPTH=3 ----------------
   logic        s_tvalid_a, s_tready_a, k_in_valid_a, m_tvalid_a, m_tready_a;
   logic [15:0] s_tdata_a, k_in_data_a, k_out_data_a, m_tdata_a, ka;
   logic [1:0]  s_tdest_a, m_tdest_a, credits_used_a;
   logic [17:0] qa [$];

   axis_pe_pipe #(.DATA_W(16), .DEST_W(2), .LATENCY(1), .FIFO_DEPTH(3)) dut_a (
      .clk(clk), .reset(reset),
      .s_tvalid(s_tvalid_a), .s_tready(s_tready_a), .s_tdata(s_tdata_a), .s_tdest(s_tdest_a),
      .k_in_valid(k_in_valid_a), .k_in_data(k_in_data_a), .k_out_data(k_out_data_a),
      .m_tvalid(m_tvalid_a), .m_tready(m_tready_a), .m_tdata(m_tdata_a), .m_tdest(m_tdest_a),
      .credits_used(credits_used_a)
   );

   // kernel model A: one-edge latency
   always @(posedge clk) ka <= k_in_data_a + 16'd1;
   assign k_out_data_a = ka;

   // ---------------- sweep instance B: LATENCY=5, FIFO_DEPTH=2 ----------------
   logic        s_tvalid_b, s_tready_b, k_in_valid_b, m_tvalid_b, m_tready_b;
   logic [15:0] s_tdata_b, k_in_data_b, k_out_data_b, m_tdata_b;
   logic [15:0] kb [5];
   logic [1:0]  s_tdest_b, m_tdest_b, credits_used_b;
   logic [17:0] qb [$];

   axis_pe_pipe #(.DATA_W(16), .DEST_W(2), .LATENCY(5), .FIFO_DEPTH(2)) dut_b (
      .clk(clk), .reset(reset),
      .s_tvalid(s_tvalid_b), .s_tready(s_tready_b), .s_tdata(s_tdata_b), .s_tdest(s_tdest_b),
      .k_in_valid(k_in_valid_b), .k_in_data(k_in_data_b), .k_out_data(k_out_data_b),
      .m_tvalid(m_tvalid_b), .m_tready(m_tready_b), .m_tdata(m_tdata_b), .m_tdest(m_tdest_b),
      .credits_used(credits_used_b)
   );

   // kernel model B: five-edge latency
   always @(posedge clk) begin
      kb[0] <= k_in_data_b + 16'd1;
      for (int i = 1; i < 5; i++) kb[i] <= kb[i-1];
   end
   assign k_out_data_b = kb[4];

   // credits may never exceed the FIFO depth; beyond it a result would be lost
   always @(negedge clk) begin
      if (!reset && (credits_used > 6'd32 || credits_used_a > 2'd3 || credits_used_b > 2'd2)) begin
         $display("FAIL credit_overflow: main=%0d a=%0d b=%0d", credits_used, credits_used_a, credits_used_b);
         $fatal(1);
      end
   end

   // watchdog
   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // advance to just after the next rising edge (input drive point)
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      s_tvalid = 0; s_tdata = '0; s_tdest = 0; m_tready = 0;
      s_tvalid_a = 0; s_tdata_a = '0; s_tdest_a = '0; m_tready_a = 0;
      s_tvalid_b = 0; s_tdata_b = '0; s_tdest_b = '0; m_tready_b = 0;
      reset = 1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL reset_s_tready: got %b want 0", s_tready); end
      checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_m_tvalid: got %b want 0", m_tvalid); end
      checks++; if (m_tdata !== 128'd0 || m_tdest !== 1'b0) begin errors++; $display("FAIL reset_m_tdata: got %h/%b want 0/0", m_tdata, m_tdest); end
      checks++; if (credits_used !== 6'd0) begin errors++; $display("FAIL reset_credits: got %0d want 0", credits_used); end
      checks++; if (s_tready_a !== 1'b0 || s_tready_b !== 1'b0) begin errors++; $display("FAIL reset_sweep_ready: got %b%b want 00", s_tready_a, s_tready_b); end
      step();
      reset = 0;
   endtask

   task automatic test_single();
      int acc_edge, vld_edge, n;
      m_tready = 1; s_tvalid = 1; s_tdata = 128'h1234; s_tdest = 1;
      @(negedge clk);
      checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b want 1", s_tready); end
      acc_edge = cyc + 1;
      step();
      s_tvalid = 0; s_tdata = '0; s_tdest = 0;
      @(negedge clk);
      checks++; if (credits_used !== 6'd1) begin errors++; $display("FAIL single_credits_flight: got %0d want 1", credits_used); end
      n = 0;
      while (!m_tvalid && n < 40) begin @(negedge clk); n++; end
      vld_edge = cyc;
      checks++; if (!m_tvalid) begin errors++; $display("FAIL single_timeout: m_tvalid got 0 want 1 within 40 cycles"); end
      checks++; if (vld_edge - acc_edge !== 20) begin errors++; $display("FAIL single_latency: got %0d want 20", vld_edge - acc_edge); end
      checks++; if (m_tdata !== 128'h1235 || m_tdest !== 1'b1) begin errors++; $display("FAIL single_data: got %h/%b want 1235/1", m_tdata, m_tdest); end
      @(negedge clk);
      checks++; if (credits_used !== 6'd0 || m_tvalid !== 1'b0) begin errors++; $display("FAIL single_after_pop: credits %0d valid %b want 0/0", credits_used, m_tvalid); end
      step();
   endtask

   task automatic test_stream();
      int sent, got, first_acc, first_out, last_out;
      bit gap;
      beat_t want;
      sent = 0; got = 0; first_acc = -1; first_out = -1; last_out = -1; gap = 0;
      m_tready = 1;
      for (int c = 0; c < 90 && got < 25; c++) begin
         s_tvalid = (sent < 25); s_tdata = 128'(sent); s_tdest = sent[0];
         @(negedge clk);
         if (s_tvalid) begin
            checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL stream_ready: beat %0d got 0 want 1", sent); end
         end
         if (m_tvalid && m_tready) begin
            checks++;
            if (exp_q.size() == 0) begin errors++; $display("FAIL stream_order: unexpected %h/%b", m_tdata, m_tdest); end
            else begin
               want = exp_q.pop_front();
               if ({m_tdata, m_tdest} !== want) begin errors++; $display("FAIL stream_order: got %h/%b want %h/%b", m_tdata, m_tdest, want.data, want.dest); end
            end
            if (first_out < 0) first_out = cyc; else if (cyc != last_out + 1) gap = 1;
            last_out = cyc; got++;
         end
         if (s_tvalid && s_tready) begin
            if (first_acc < 0) first_acc = cyc + 1;
            exp_q.push_back({s_tdata + 128'd1, s_tdest});
            sent++;
         end
         step();
      end
      s_tvalid = 0;
      checks++; if (got !== 25) begin errors++; $display("FAIL stream_count: got %0d want 25", got); end
      checks++; if (first_out - first_acc !== 20) begin errors++; $display("FAIL stream_latency: got %0d want 20", first_out - first_acc); end
      checks++; if (gap !== 1'b0) begin errors++; $display("FAIL stream_gap: outputs not consecutive got 1 want 0"); end
   endtask

   task automatic test_backpressure();
      int acc;
      logic [127:0] held;
      bit have, held_ok;
      acc = 0; have = 0; held_ok = 1;
      m_tready = 0; s_tvalid = 1;
      for (int c = 0; c < 70; c++) begin
         s_tdata = (acc == 0) ? 128'd0 : rnd128(); s_tdest = 1'($urandom);
         @(negedge clk);
         if (m_tvalid) begin
            if (!have) begin held = m_tdata; have = 1; end
            else if (m_tdata !== held) held_ok = 0;
         end
         if (s_tvalid && s_tready) begin exp_q.push_back({s_tdata + 128'd1, s_tdest}); acc++; end
         step();
      end
      @(negedge clk);
      checks++; if (acc !== 32) begin errors++; $display("FAIL bp_accepts: got %0d want 32", acc); end
      checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL bp_ready: got %b want 0", s_tready); end
      checks++; if (credits_used !== 6'd32) begin errors++; $display("FAIL bp_credits: got %0d want 32", credits_used); end
      checks++; if (m_tvalid !== 1'b1 || m_tdata !== 128'd1) begin errors++; $display("FAIL bp_head: got %b/%h want 1/1", m_tvalid, m_tdata); end
      checks++; if (held_ok !== 1'b1) begin errors++; $display("FAIL bp_stable: head changed while stalled got 0 want 1"); end
      step();
   endtask

   task automatic test_full_boundary();
      beat_t want;
      // edge X: full, pop only
      m_tready = 1; s_tvalid = 1; s_tdata = rnd128(); s_tdest = 1'($urandom);
      for (int k = 0; k < 3; k++) begin
         if (k == 2) m_tready = 0;
         @(negedge clk);
         if (k == 0) begin
            checks++; if (s_tready !== 1'b0 || credits_used !== 6'd32) begin errors++; $display("FAIL full_at_limit: ready %b credits %0d want 0/32", s_tready, credits_used); end
         end else if (k == 1) begin
            checks++; if (s_tready !== 1'b1 || credits_used !== 6'd31) begin errors++; $display("FAIL full_reopen: ready %b credits %0d want 1/31", s_tready, credits_used); end
         end else begin
            checks++; if (credits_used !== 6'd31) begin errors++; $display("FAIL full_accept_pop: credits got %0d want 31", credits_used); end
         end
         if (m_tvalid && m_tready) begin
            checks++;
            want = exp_q.pop_front();
            if ({m_tdata, m_tdest} !== want) begin errors++; $display("FAIL full_order: got %h/%b want %h/%b", m_tdata, m_tdest, want.data, want.dest); end
         end
         if (s_tvalid && s_tready) exp_q.push_back({s_tdata + 128'd1, s_tdest});
         step();
         s_tdata = rnd128(); s_tdest = 1'($urandom);
      end
      s_tvalid = 0;
      @(negedge clk);
      checks++; if (credits_used !== 6'd32 || s_tready !== 1'b0) begin errors++; $display("FAIL full_refill: credits %0d ready %b want 32/0", credits_used, s_tready); end
      step();
   endtask

   task automatic test_drain();
      beat_t want;
      m_tready = 1; s_tvalid = 0;
      for (int c = 0; c < 120 && exp_q.size() > 0; c++) begin
         @(negedge clk);
         if (m_tvalid && m_tready) begin
            checks++;
            want = exp_q.pop_front();
            if ({m_tdata, m_tdest} !== want) begin errors++; $display("FAIL drain_order: got %h/%b want %h/%b", m_tdata, m_tdest, want.data, want.dest); end
         end
         step();
      end
      @(negedge clk);
      checks++; if (exp_q.size() != 0 || credits_used !== 6'd0 || m_tvalid !== 1'b0) begin
         errors++; $display("FAIL drain_empty: missing %0d credits %0d valid %b want 0/0/0", exp_q.size(), credits_used, m_tvalid);
      end
      step();
   endtask

   task automatic test_random();
      beat_t want;
      logic [128:0] prev;
      bit prev_stall;
      prev_stall = 0; prev = '0;
      for (int c = 0; c < 400; c++) begin
         s_tvalid = ($urandom_range(0, 1) == 1); s_tdata = rnd128(); s_tdest = 1'($urandom);
         m_tready = ($urandom_range(0, 9) < 4);
         @(negedge clk);
         checks++; if (int'(credits_used) != exp_q.size()) begin errors++; $display("FAIL rand_credits: got %0d want %0d", credits_used, exp_q.size()); end
         checks++; if (s_tready !== (exp_q.size() < 32)) begin errors++; $display("FAIL rand_ready: got %b want %b", s_tready, exp_q.size() < 32); end
         if (prev_stall) begin
            checks++; if ({m_tvalid, m_tdata, m_tdest} !== {1'b1, prev}) begin errors++; $display("FAIL rand_stable: got %b/%h want 1/%h", m_tvalid, {m_tdata, m_tdest}, prev); end
         end
         prev_stall = m_tvalid && !m_tready; prev = {m_tdata, m_tdest};
         if (m_tvalid && m_tready) begin
            checks++;
            if (exp_q.size() == 0) begin errors++; $display("FAIL rand_order: unexpected %h/%b", m_tdata, m_tdest); end
            else begin
               want = exp_q.pop_front();
               if ({m_tdata, m_tdest} !== want) begin errors++; $display("FAIL rand_order: got %h/%b want %h/%b", m_tdata, m_tdest, want.data, want.dest); end
            end
         end
         if (s_tvalid && s_tready) exp_q.push_back({s_tdata + 128'd1, s_tdest});
         step();
      end
      test_drain();
   endtask

   task automatic test_reset_mid();
      bit stale;
      int acc_edge, n;
      logic [127:0] d;
      m_tready = 0;
      for (int c = 0; c < 37; c++) begin
         s_tvalid = (c < 5) || (c >= 27);
         s_tdata = rnd128(); s_tdest = 1'($urandom);
         step();
      end
      s_tvalid = 0;
      @(negedge clk);
      checks++; if (credits_used !== 6'd15 || m_tvalid !== 1'b1) begin errors++; $display("FAIL rmid_pre: credits %0d valid %b want 15/1", credits_used, m_tvalid); end
      @(posedge clk); #2;
      reset = 1;
      #1;
      checks++; if (m_tvalid !== 1'b0 || credits_used !== 6'd0 || s_tready !== 1'b0) begin
         errors++; $display("FAIL rmid_async: valid %b credits %0d ready %b want 0/0/0", m_tvalid, credits_used, s_tready);
      end
      exp_q.delete();
      step();
      reset = 0;
      m_tready = 1; stale = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (m_tvalid) stale = 1;
         step();
      end
      checks++; if (stale !== 1'b0) begin errors++; $display("FAIL rmid_stale: output after reset got 1 want 0"); end
      d = rnd128();
      s_tvalid = 1; s_tdata = d; s_tdest = 0;
      @(negedge clk);
      acc_edge = cyc + 1;
      step();
      s_tvalid = 0;
      n = 0;
      @(negedge clk);
      while (!m_tvalid && n < 40) begin @(negedge clk); n++; end
      checks++; if (cyc - acc_edge !== 20 || m_tdata !== d + 128'd1 || m_tdest !== 1'b0) begin
         errors++; $display("FAIL rmid_fresh: latency %0d data %h want 20/%h", cyc - acc_edge, m_tdata, d + 128'd1);
      end
      step();
      step();
   endtask

   task automatic test_sweep_a();
      logic [17:0] want;
      for (int c = 0; c < 140; c++) begin
         // random phase, then an empty-out phase, then a full-rate phase
         if (c < 60) begin s_tvalid_a = ($urandom_range(0, 1) == 1); m_tready_a = ($urandom_range(0, 1) == 1); end
         else if (c < 80) begin s_tvalid_a = 0; m_tready_a = 1; end
         else begin s_tvalid_a = (c < 120); m_tready_a = 1; end
         s_tdata_a = 16'($urandom); s_tdest_a = 2'($urandom);
         @(negedge clk);
         checks++; if (int'(credits_used_a) != qa.size()) begin errors++; $display("FAIL swa_credits: got %0d want %0d", credits_used_a, qa.size()); end
         if (c >= 80 && s_tvalid_a) begin
            checks++; if (s_tready_a !== 1'b1) begin errors++; $display("FAIL swa_rate: ready got 0 want 1 at step %0d", c); end
         end
         if (m_tvalid_a && m_tready_a) begin
            checks++;
            if (qa.size() == 0) begin errors++; $display("FAIL swa_order: unexpected %h/%h", m_tdata_a, m_tdest_a); end
            else begin
               want = qa.pop_front();
               if ({m_tdata_a, m_tdest_a} !== want) begin errors++; $display("FAIL swa_order: got %h want %h", {m_tdata_a, m_tdest_a}, want); end
            end
         end
         if (s_tvalid_a && s_tready_a) qa.push_back({s_tdata_a + 16'd1, s_tdest_a});
         step();
      end
      checks++; if (qa.size() != 0) begin errors++; $display("FAIL swa_lost: got %0d missing want 0", qa.size()); end
      s_tvalid_a = 0;
   endtask

   task automatic test_sweep_b();
      logic [17:0] want;
      int acc_edges [$];
      // Both slots are in use until the first result pops at A+LATENCY+1.
      // A credit freed by that pop is reused at the next edge, so accepts
      // i and i+2 are LATENCY+2 = 7 edges apart.
      m_tready_b = 1; s_tvalid_b = 1;
      for (int c = 0; c < 50; c++) begin
         s_tdata_b = 16'($urandom); s_tdest_b = 2'($urandom);
         if (c == 40) s_tvalid_b = 0;
         @(negedge clk);
         checks++; if (int'(credits_used_b) != qb.size()) begin errors++; $display("FAIL swb_credits: got %0d want %0d", credits_used_b, qb.size()); end
         if (m_tvalid_b && m_tready_b) begin
            checks++;
            if (qb.size() == 0) begin errors++; $display("FAIL swb_order: unexpected %h/%h", m_tdata_b, m_tdest_b); end
            else begin
               want = qb.pop_front();
               if ({m_tdata_b, m_tdest_b} !== want) begin errors++; $display("FAIL swb_order: got %h want %h", {m_tdata_b, m_tdest_b}, want); end
            end
         end
         if (s_tvalid_b && s_tready_b) begin
            qb.push_back({s_tdata_b + 16'd1, s_tdest_b});
            acc_edges.push_back(cyc + 1);
         end
         step();
      end
      checks++; if (acc_edges.size() < 10) begin errors++; $display("FAIL swb_count: got %0d accepts want >= 10", acc_edges.size()); end
      for (int i = 0; i + 2 < acc_edges.size(); i++) begin
         checks++;
         if (acc_edges[i+2] - acc_edges[i] != 7) begin errors++; $display("FAIL swb_rate: accept spacing got %0d want 7", acc_edges[i+2] - acc_edges[i]); end
      end
      checks++; if (qb.size() != 0) begin errors++; $display("FAIL swb_lost: got %0d missing want 0", qb.size()); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_stream();
      test_backpressure();
      test_full_boundary();
      test_drain();
      test_random();
      test_reset_mid();
      test_sweep_a();
      test_sweep_b();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
